sdram_bus_master: RTL

- 68000-style bus initiator that drives the CPU-side port of the SDRAM controller (addr/din/dout/uds/lds/oe/we/dtack).
- Used by DMA-style agents (screen fetch, block copy) that need sequential word reads or writes without the CPU.
- Accepts one command of 1..256 consecutive words, generates correct 68k cycle sequencing per word and streams data in or out.
- Guards every cycle with a dtack timeout.

---
 rtl/sdram_bus_master.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_bus_master.sv
// 68000-style bus initiator for the SDRAM controller CPU port.
// Runs bursts of 1..256 sequential word reads or writes, and aborts a burst if dtack never arrives.
module sdram_bus_master #(
    parameter int SAMPLE_DELAY = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [1:0]  cmd_be,
    input  logic [15:0] wdata,
    output logic        wdata_ack,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        error,
    output logic [23:0] bus_addr,
    output logic [15:0] bus_din,
    input  logic [15:0] bus_dout,
    output logic        bus_uds,
    output logic        bus_lds,
    output logic        bus_oe,
    output logic        bus_we,
    input  logic        bus_dtack
);

    typedef enum logic [2:0] {
        IDLE, RWAIT, START, STROBE, ACK, SAMPLE, RELEASE, DONE
    } state_t;

    localparam logic [3:0] SMP_LAST = 4'(SAMPLE_DELAY - 1);
    localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic        wr_q, wr_d;
    logic [1:0]  be_q, be_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [3:0]  smp_q, smp_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        wdata_ack_q, wdata_ack_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic        uds_q, uds_d;
    logic        lds_q, lds_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            len_q         <= '0;
            wr_q          <= 1'b0;
            be_q          <= '0;
            tmo_q         <= '0;
            smp_q         <= '0;
            cmd_ready_q   <= 1'b1;
            wdata_ack_q   <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            uds_q         <= 1'b0;
            lds_q         <= 1'b0;
            oe_q          <= 1'b0;
            we_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            wr_q          <= wr_d;
            be_q          <= be_d;
            tmo_q         <= tmo_d;
            smp_q         <= smp_d;
            cmd_ready_q   <= cmd_ready_d;
            wdata_ack_q   <= wdata_ack_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            error_q       <= error_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            uds_q         <= uds_d;
            lds_q         <= lds_d;
            oe_q          <= oe_d;
            we_q          <= we_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        wr_d          = wr_q;
        be_d          = be_q;
        tmo_d         = '0;
        smp_d         = '0;
        wdata_ack_d   = 1'b0;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        error_d       = error_q;
        addr_d        = addr_q;
        din_d         = din_q;
        uds_d         = uds_q;
        lds_d         = lds_q;
        oe_d          = oe_q;
        we_d          = we_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    wr_d    = cmd_write;
                    be_d    = cmd_be;
                    error_d = 1'b0;
                    state_d = RWAIT;
                end
            end
            // A dtack still high from the previous word must drain before a new cycle starts.
            RWAIT: begin
                if (!bus_dtack) begin
                    state_d = START;
                end else if (tmo_q == TMO_MAX) begin
                    error_d = 1'b1;
                    {oe_d, we_d, uds_d, lds_d} = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            START: begin
                if (wr_q) begin
                    we_d        = 1'b1;
                    din_d       = wdata;
                    wdata_ack_d = 1'b1;
                    state_d     = STROBE;
                end else begin
                    oe_d    = 1'b1;
                    uds_d   = 1'b1;
                    lds_d   = 1'b1;
                    state_d = ACK;
                end
            end
            STROBE: begin
                {uds_d, lds_d} = be_q;
                state_d        = ACK;
            end
            ACK: begin
                if (bus_dtack) begin
                    state_d = wr_q ? RELEASE : SAMPLE;
                end else if (tmo_q == TMO_MAX) begin
                    error_d = 1'b1;
                    {oe_d, we_d, uds_d, lds_d} = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            SAMPLE: begin
                if (smp_q == SMP_LAST) begin
                    rdata_d       = bus_dout;
                    rdata_valid_d = 1'b1;
                    state_d       = RELEASE;
                end else begin
                    smp_d = smp_q + 4'd1;
                end
            end
            // Write strobes have been held one cycle past dtack by the time this state drops them.
            RELEASE: begin
                {oe_d, we_d, uds_d, lds_d} = '0;
                if (len_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    len_d   = len_q - 8'd1;
                    addr_d  = addr_q + 24'd1;
                    state_d = RWAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    assign cmd_ready   = cmd_ready_q;
    assign wdata_ack   = wdata_ack_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign error       = error_q;
    assign bus_addr    = addr_q;
    assign bus_din     = din_q;
    assign bus_uds     = uds_q;
    assign bus_lds     = lds_q;
    assign bus_oe      = oe_q;
    assign bus_we      = we_q;

endmodule
